// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming encode/transmit path.
// Codeword positions are 1-based; powers of two hold parity.
package hamming_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  function automatic int code_width(input int ip_bit);
    return ip_bit + 4;
  endfunction

  function automatic bit is_parity_pos(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational Hamming(IP_BIT+4, IP_BIT) encoder with a one-bit
// error injector; position p of the codeword sits at bit CW-p.
module hamming_enc_core
  import hamming_pkg::*;
#(
  parameter int IP_BIT = 8,
  localparam int CW = code_width(IP_BIT)
) (
  input  logic [IP_BIT-1:0] in_data,
  input  logic [3:0]        inj_pos,
  output logic [CW-1:0]     code
);

  // Data positions at or below p (1-based rank of a data position).
  function automatic int data_rank(input int p);
    int n;
    n = 0;
    for (int q = 1; q <= p; q++)
      if (!is_parity_pos(q)) n++;
    return n;
  endfunction

  // Data positions whose index has bit k set.
  function automatic logic [CW-1:0] cover_mask(input int k);
    logic [CW-1:0] m;
    m = '0;
    for (int p = 1; p <= CW; p++)
      if (!is_parity_pos(p) && ((p >> k) & 1) == 1)
        m = m | ({{(CW-1){1'b0}}, 1'b1} << (CW - p));
    return m;
  endfunction

  logic [CW-1:0] dvec;
  logic [CW-1:0] pvec;
  logic [CW-1:0] flip;
  logic [3:0]    par;

  for (genvar p = 1; p <= CW; p++) begin : g_pos
    if (is_parity_pos(p)) begin : g_par
      assign dvec[CW-p] = 1'b0;
      assign pvec[CW-p] = par[$clog2(p)];
    end else begin : g_dat
      assign dvec[CW-p] = in_data[IP_BIT-data_rank(p)];
      assign pvec[CW-p] = 1'b0;
    end
    assign flip[CW-p] = (inj_pos == 4'(p));
  end

  for (genvar k = 0; k < 4; k++) begin : g_chk
    assign par[k] = ^(dvec & cover_mask(k));
  end

  assign code = (dvec | pvec) ^ flip;

endmodule

// File: rtl/hamming_enc_tx.sv
// Hamming encoder + serial transmitter, position 1 first.
// Back-to-back words reload on the last bit with no bubble.
module hamming_enc_tx
  import hamming_pkg::*;
#(
  parameter int IP_BIT = 8,
  localparam int CW = code_width(IP_BIT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IP_BIT-1:0] in_data,
  input  logic [3:0]        inj_pos,
  output logic              code_valid,
  output logic [CW-1:0]     out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last
);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] shreg;
  logic [CW-1:0] enc_code;
  logic          accept;
  logic          beat;

  hamming_enc_core #(
    .IP_BIT (IP_BIT)
  ) u_core (
    .in_data (in_data),
    .inj_pos (inj_pos),
    .code    (enc_code)
  );

  // Handshake and serial outputs decoded from the current state.
  always_comb begin
    out_valid = (state == SEND);
    out_last  = (state == SEND) && (bit_cnt == 4'(CW - 1));
    out_bit   = (state == SEND) && shreg[CW-1];
    beat      = out_valid && out_ready;
    in_ready  = (state == IDLE) || (beat && out_last);
    accept    = in_valid && in_ready;
  end

  // Next-state: start on a word, leave SEND on the last beat.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = SEND;
      SEND: if (beat && out_last)
              state_nxt = in_valid ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Codeword capture, shifter and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      out_code   <= '0;
      code_valid <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      code_valid <= accept;
      if (accept) begin
        shreg    <= enc_code;
        out_code <= enc_code;
        bit_cnt  <= '0;
      end else if (beat) begin
        shreg   <= shreg << 1;
        bit_cnt <= out_last ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_enc_tx.sv
// Directed bench for hamming_enc_tx (IP_BIT=8, 12-bit codeword).
// Expected codewords are hand-computed constants.
module tb_hamming_enc_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  inj_pos;
  logic        code_valid;
  logic [11:0] out_code;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic        out_last;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_enc_tx #(
    .IP_BIT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .inj_pos    (inj_pos),
    .code_valid (code_valid),
    .out_code   (out_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_last   (out_last)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] bitof(input logic [11:0] c, input int p);
    return (c >> (12 - p)) & 12'd1;
  endfunction

  function automatic logic [3:0] syndrome(input logic [11:0] c);
    logic [3:0] s;
    s = '0;
    for (int p = 1; p <= 12; p++)
      if (bitof(c, p) != 0) s = s ^ 4'(p);
    return s;
  endfunction

  function automatic logic [7:0] decode(input logic [11:0] c);
    logic [3:0]  s;
    logic [11:0] f;
    logic [7:0]  d;
    s = syndrome(c);
    f = c;
    if (s >= 4'd1 && s <= 4'd12) f = f ^ (12'd1 << (12 - int'(s)));
    d = '0;
    for (int p = 1; p <= 12; p++)
      if (p != 1 && p != 2 && p != 4 && p != 8)
        d = {d[6:0], bitof(f, p) != 0};
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag,
                           input logic [7:0] d,
                           input logic [3:0] inj,
                           input logic [11:0] exp,
                           input bit stall,
                           input bit noise);
    logic [11:0] got;
    logic [3:0]  exp_syn;
    int          n;
    int          cyc;
    bit          prev_stall;
    logic        prev_bit;
    logic        prev_last;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check({tag, "_rdy"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    inj_pos  = inj;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    inj_pos  = 4'd0;
    check({tag, "_cv"}, code_valid, 1'b1);
    check({tag, "_code"}, out_code, exp);
    got = '0;
    n = 0;
    cyc = 0;
    prev_stall = 0;
    prev_bit = 0;
    prev_last = 0;
    while (n < 12 && cyc < 200) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = noise && (n < 11);
      in_data   = 8'h5A;
      inj_pos   = 4'd7;
      #1;
      if (!out_valid) begin
        check({tag, "_ov"}, out_valid, 1'b1);
        break;
      end
      if (prev_stall) begin
        check({tag, "_hold_bit"}, out_bit, prev_bit);
        check({tag, "_hold_last"}, out_last, prev_last);
      end
      check({tag, "_last"}, out_last, n == 11);
      check({tag, "_irdy"}, in_ready, out_ready && n == 11);
      prev_stall = !out_ready;
      prev_bit = out_bit;
      prev_last = out_last;
      if (out_ready) begin
        got[11-n] = out_bit;
        n++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_timeout"}, n, 12);
    check({tag, "_stream"}, got, exp);
    check({tag, "_idle"}, out_valid, 1'b0);
    check({tag, "_code_hold"}, out_code, exp);
    exp_syn = (inj <= 4'd12) ? inj : 4'd0;
    check({tag, "_syn"}, syndrome(got), exp_syn);
    check({tag, "_dec"}, decode(got), d);
  endtask

  initial begin : main
    logic [23:0] stream;
    int vcnt;
    int rcnt;
    int ccnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    inj_pos   = 4'd0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_code", out_code, 12'h000);
    check("rst_cv", code_valid, 1'b0);
    check("rst_ov", out_valid, 1'b0);
    check("rst_bit", out_bit, 1'b0);
    check("rst_last", out_last, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_irdy", in_ready, 1'b1);

    run_frame("a5", 8'hA5, 4'd0, 12'hE45, 0, 0);
    run_frame("ff", 8'hFF, 4'd0, 12'hEEF, 0, 0);
    run_frame("00", 8'h00, 4'd0, 12'h000, 0, 0);
    run_frame("inj3", 8'hA5, 4'd3, 12'hC45, 0, 0);
    run_frame("inj14", 8'hA5, 4'd14, 12'hE45, 0, 0);
    run_frame("inj12", 8'hFF, 4'd12, 12'hEEE, 0, 0);
    run_frame("stall", 8'hA5, 4'd0, 12'hE45, 1, 0);
    run_frame("noise", 8'h3C, 4'd0, 12'h46C, 1, 1);

    in_valid = 1'b1;
    in_data  = 8'hA5;
    inj_pos  = 4'd0;
    tick();
    in_data = 8'hFF;
    stream = '0;
    vcnt = 0;
    rcnt = 0;
    ccnt = code_valid ? 1 : 0;
    for (int i = 0; i < 24; i++) begin
      if (out_valid) vcnt++;
      if (in_ready) rcnt++;
      stream = {stream[22:0], out_bit};
      tick();
      if (i == 11) in_valid = 1'b0;
      if (code_valid) ccnt++;
    end
    check("b2b_valid", vcnt, 24);
    check("b2b_irdy", rcnt, 2);
    check("b2b_cv", ccnt, 2);
    check("b2b_stream", stream, 24'hE45EEF);
    check("b2b_code", out_code, 12'hEEF);
    check("b2b_idle", out_valid, 1'b0);

    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_ov", out_valid, 1'b1);
    check("mid_irdy", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    check("mrst_code", out_code, 12'h000);
    check("mrst_cv", code_valid, 1'b0);
    check("mrst_ov", out_valid, 1'b0);
    check("mrst_bit", out_bit, 1'b0);
    check("mrst_last", out_last, 1'b0);
    check("mrst_irdy", in_ready, 1'b1);
    rst = 1'b0;
    run_frame("post", 8'h3C, 4'd0, 12'h46C, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_enc_tx.md
Name: hamming_enc_tx

Overview:
Hamming(IP_BIT+4, IP_BIT) single-error-correcting encoder and serial transmitter. It is the transmit-side counterpart of the team's Hamming decode IP. It accepts data words over a valid/ready handshake and computes 4 even-parity bits. It presents the full codeword in parallel and shifts it out serially, position 1 first. An optional single-bit error injector lets benches exercise the decoder's correction path end to end.

Parameters:
- IP_BIT, 8: data width. Legal range is 5..11, so CW = IP_BIT+4 ≤ 15 and the syndrome fits in 4 bits.
- CW (localparam), IP_BIT+4: codeword width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  data word offered
- in_ready  out  1  block can accept a word this cycle
- in_data  in  IP_BIT  data word; MSB maps to the lowest data position
- inj_pos  in  4  error injection position, sampled with the word. 0 = none; 1..CW flips that codeword position; >CW is ignored.
- code_valid  out  1  one-cycle pulse when out_code updates
- out_code  out  CW  registered codeword. Position p (1-based) sits at bit CW-p, so position 1 is the MSB.
- out_valid  out  1  serial bit valid
- out_ready  in  1  serial sink accepts the bit
- out_bit  out  1  current serial bit
- out_last  out  1  high with the bit at position CW

Behaviour:
- Codeword layout:
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits fill the remaining positions 3, 5, 6, 7, 9, ..., CW in ascending order; in_data MSB goes to position 3.
  - The parity bit at position 2^k is the XOR of all data positions p with bit k of p set. This gives even parity: the XOR of the indices of all set positions is 0.
- Error injection is applied after parity generation. The bit at position inj_pos is inverted if 1 ≤ inj_pos ≤ CW.
- State machine:
  - States: IDLE, SEND.
  - bit_cnt runs 0..CW-1; shreg has CW bits.
  - IDLE: in_ready=1, out_valid=0. On in_valid (handshake at edge T):
    - load shreg and out_code with the encoded/injected word;
    - pulse code_valid at T+1;
    - bit_cnt=0, go to SEND.
  - SEND: out_valid=1, out_bit=shreg MSB, out_last=(bit_cnt==CW-1).
    - Each out_valid&&out_ready: shift left, bit_cnt++.
    - If out_ready=0: hold out_bit, out_last and bit_cnt stable.
  - In SEND, in_ready = out_ready && out_last (combinational), so back-to-back frames have no bubble.
    - Last bit and new word handshake in the same cycle: reload, stay in SEND, bit_cnt=0, pulse code_valid.
    - Last bit without a new word: go to IDLE.
- Latency: word accepted at edge T → out_code/code_valid and the first serial bit are visible after T+1. A full frame takes CW accepted beats.
- in_valid while in_ready=0: no effect. in_data and inj_pos are not captured.
- Reset (any cycle, including mid-frame):
  - state=IDLE, bit_cnt=0, shreg=0;
  - out_code=0, code_valid=0, out_valid=0, out_bit=0, out_last=0;
  - a partial frame is dropped.
- in_ready is 1 one cycle after reset is released.
- out_code holds its value until the next accepted word.

Decomposition:
- hamming_pkg holds:
  - is_parity_pos function (p is a power of two);
  - code_width function (IP_BIT+4);
  - the state enum {IDLE, SEND}.
- hamming_enc_core is one combinational sub-module (in_data, inj_pos → codeword), instantiated once. Benches reuse it as the reference encoder.

Test Plan:
- IP_BIT=8, in_data=8'hA5, inj_pos=0, out_ready=1 → out_code=12'hE45. Serial stream is 1,1,1,0,0,1,0,0,0,1,0,1, with out_last on the 12th bit.
- in_data=8'hFF → 12'hEEF. in_data=8'h00 → 12'h000. Feeding each output to the decode IP returns the original data.
- in_data=8'hA5, inj_pos=3 → out_code=12'hC45; the decode IP outputs 8'hA5. inj_pos=14 → 12'hE45 (ignored).
- Two words in consecutive frames with in_valid held high and out_ready=1 → 24 contiguous out_valid cycles with no gap. in_ready pulses only on each out_last cycle, and code_valid fires twice.
- out_ready toggled randomly mid-frame → out_bit/out_last stay stable while stalled, the bit sequence is unchanged, and in_ready stays 0 until the last bit is accepted.
- rst asserted at bit 5 of a frame → next cycle all outputs are 0 and in_ready=1. A new word 8'h3C then produces a complete, correct 12-bit frame.
